nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit ripple-carry adder slice, one nibble per cycle, LSB nibble first. Carry is registered between cycles. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake. Used wherever a wide adder is too costly and multi-cycle latency is acceptable.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. NIBBLES = WIDTH/4 (derived).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB; for sub, 1 = no borrow
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: async on rst_n low, overriding everything. State goes to IDLE; sum=0, cout=0, ovf=0, out_valid=0; working registers and nibble index clear. in_ready is forced to 0 while rst_n is low.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE) && rst_n.
- IDLE:
  - On in_valid && in_ready, latch a_reg=a and b_reg = sub ? ~b : b.
  - Set carry_reg = sub ? 1 : cin, idx=0, and go to RUN.
  - With no in_valid, stay in IDLE.
- RUN, one nibble per cycle:
  - The slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry_reg.
  - The 4-bit result goes to work_sum[4*idx+:4]; carry_reg takes the slice cout; idx increments.
  - The cycle with idx==NIBBLES-1 is the last; the next state is DONE.
- DONE entry, same edge as the last RUN cycle:
  - sum <= work_sum (including the final nibble) and cout <= final slice carry.
  - ovf <= (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (result MSB != a_reg[WIDTH-1]).
  - out_valid <= 1.
- Latency: input accepted at edge k gives out_valid high after edge k+NIBBLES. For WIDTH=4 there is 1 RUN cycle.
- DONE: out_valid=1. sum/cout/ovf hold stable until out_valid && out_ready, then out_valid <= 0 and the next state is IDLE.
- Throughput: one transaction per NIBBLES+2 cycles minimum (IDLE, NIBBLES x RUN, DONE); there is no overlap.
- After the output handshake, sum/cout/ovf keep their last values (not cleared) until the next DONE entry.
- Outside IDLE, in_valid is ignored (in_ready=0). Changes on a/b/cin/sub after acceptance have no effect.
- out_ready outside DONE has no effect.
- Reset asserted mid-RUN or in DONE aborts the operation and discards the result. The first transaction after release is correct.
- All arithmetic is modulo 2^WIDTH. Carry chains across nibble boundaries only through carry_reg.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 -> sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge, lasts 1 cycle; in_ready=1 the following cycle.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry propagates through all 4 nibbles). Also a=0x000F, b=0x0000, cin=1 -> sum=0x0010, cout=0.
- a=0x7FFF, b=0x0001 add -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 add -> sum=0x0000, cout=1, ovf=1.
- sub=1: a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored). a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands driven -> out_valid, sum, cout, ovf stable and in_ready=0 throughout, new operands not accepted. Then out_ready=1 -> one handshake, IDLE next cycle, pending operands accepted.
- Reset: pull rst_n low asynchronously during the 3rd RUN cycle -> out_valid/sum/cout/ovf=0 and in_ready=0 immediately without a clock edge. After release, a=0x0001, b=0x0002 -> sum=0x0003 after 4 cycles. Repeat with WIDTH=4: a=0xF, b=0x1 -> sum=0x0, cout=1 after 1 cycle.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Purpose: WIDTH-bit add/subtract built from one reused 4-bit slice, LSB nibble first.
// Latency: operands accepted at edge k give out_valid after edge k+WIDTH/4; no overlap.
// Backpressure: result and out_valid are held in DONE until out_ready; in_ready is low outside IDLE.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   operand handshake for a, b, cin, sub
//   a, b                operands (WIDTH bits)
//   cin                 carry-in for add; ignored when sub=1
//   sub                 0: a+b+cin, 1: a-b (as a+~b+1)
//   out_valid/out_ready result handshake for sum, cout, ovf
//   sum, cout, ovf      result, MSB carry (no-borrow for sub), signed overflow
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // already inverted for subtract
  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_slice;
  logic [WIDTH-1:0] w_work_next;
  logic             w_last;
  logic             w_ovf;

  // Gated by rst_n so the block never advertises ready while held in reset.
  assign in_ready = (r_state == IDLE) && rst_n;

  // Nibble select and write-back use constant slices driven by a compare
  // against the index, keeping the mux shallow and the part-selects static.
  always_comb begin
    w_a_nib     = '0;
    w_b_nib     = '0;
    w_work_next = r_work;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
    w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_work_next[4*n +: 4] = w_slice[3:0];
      end
    end
  end

  assign w_last = (r_idx == IDXW'(NIBBLES - 1));
  // Overflow uses the effective (possibly inverted) B operand, which makes the
  // same rule cover add and subtract.
  assign w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                  (w_work_next[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_work    <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_work  <= w_work_next;
          r_carry <= w_slice[4];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            // Publish directly from the slice so the final nibble is included.
            sum       <= w_work_next;
            cout      <= w_slice[4];
            ovf       <= w_ovf;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Purpose: directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16 and WIDTH=4).
// Latency: expects out_valid NIBBLES cycles after the accept edge.
// Backpressure: exercises a held DONE state with pending operands.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  // WIDTH=16 instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  // WIDTH=4 instance
  logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Present one operand set for one cycle; called and returns at a negedge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin, input logic tsub);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid; a large count signals a timeout.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vecs++; if (sum !== 16'h0000) begin errs++; $display("FAIL reset_sum got %h want 0000", sum); end
    vecs++; if (cout !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL reset_flags got %b%b want 00", cout, ovf); end
    #11 rst_n = 1'b1;
    @(negedge clk);
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_basic;
    int n;
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL basic_busy in_ready got %b want 0", in_ready); end
    wait_out(n);
    vecs++; if (n !== 4) begin errs++; $display("FAIL basic_latency got %0d want 4", n); end
    vecs++; if (sum !== 16'h5555) begin errs++; $display("FAIL basic_sum got %h want 5555", sum); end
    vecs++; if (cout !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL basic_flags got %b%b want 00", cout, ovf); end
    @(negedge clk);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_len got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL basic_ready_after got %b want 1", in_ready); end
  endtask

  // Table rows: a, b, cin, sub, expected sum, cout, ovf
  task automatic test_arith;
    logic [15:0] ta [8] = '{16'hFFFF, 16'h000F, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'h0000, 16'h1234};
    logic [15:0] tb_[8] = '{16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0007, 16'h0001, 16'h0000, 16'h1234};
    logic        tc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] es [8] = '{16'h0000, 16'h0010, 16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h0000, 16'h0000};
    logic        ec [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        eo [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int n;
    for (int i = 0; i < 8; i++) begin
      send(ta[i], tb_[i], tc[i], ts[i]);
      wait_out(n);
      vecs++; if (n !== 4) begin errs++; $display("FAIL arith%0d_latency got %0d want 4", i, n); end
      vecs++; if (sum !== es[i]) begin errs++; $display("FAIL arith%0d_sum got %h want %h", i, sum, es[i]); end
      vecs++; if (cout !== ec[i]) begin errs++; $display("FAIL arith%0d_cout got %b want %b", i, cout, ec[i]); end
      vecs++; if (ovf !== eo[i]) begin errs++; $display("FAIL arith%0d_ovf got %b want %b", i, ovf, eo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_out(n);
    vecs++; if (n !== 4) begin errs++; $display("FAIL bp_latency got %0d want 4", n); end
    a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vecs++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL bp_hold%0d valid/ready got %b%b want 10", i, out_valid, in_ready); end
      vecs++; if (sum !== 16'h3333 || cout !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL bp_hold%0d result got %h %b %b want 3333 0 0", i, sum, cout, ovf); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL bp_release valid/ready got %b%b want 01", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_pending_accept in_ready got %b want 0", in_ready); end
    wait_out(n);
    vecs++; if (n !== 4) begin errs++; $display("FAIL bp_pending_latency got %0d want 4", n); end
    vecs++; if (sum !== 16'hBBBB || cout !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL bp_pending_result got %h %b %b want bbbb 0 0", sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int n;
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL rst_mid valid/ready got %b%b want 00", out_valid, in_ready); end
    vecs++; if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL rst_mid result got %h %b %b want 0000 0 0", sum, cout, ovf); end
    @(negedge clk);
    @(negedge clk);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_hold out_valid got %b want 0", out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_out(n);
    vecs++; if (n !== 4) begin errs++; $display("FAIL rst_after_latency got %0d want 4", n); end
    vecs++; if (sum !== 16'h0003 || cout !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL rst_after_result got %h %b %b want 0003 0 0", sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_width4;
    int n;
    vecs++; if (in_ready4 !== 1'b1) begin errs++; $display("FAIL w4_ready got %b want 1", in_ready4); end
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; sub4 = 1'b0; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vecs++; if (n !== 1) begin errs++; $display("FAIL w4_latency got %0d want 1", n); end
    vecs++; if (sum4 !== 4'h0 || cout4 !== 1'b1 || ovf4 !== 1'b0) begin errs++; $display("FAIL w4_result got %h %b %b want 0 1 0", sum4, cout4, ovf4); end
    @(negedge clk);
    vecs++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errs++; $display("FAIL w4_return valid/ready got %b%b want 01", out_valid4, in_ready4); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
    test_reset;
    test_add_basic;
    test_arith;
    test_backpressure;
    test_reset_mid_run;
    test_width4;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
